bus_mem_responder: RTL
======================

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64, SHALL set the bus data width (bus_req and bus_resp).
REQ-002 Parameter BUS_TAG_WIDTH, default 13, SHALL set the tag width; tag bit [BUS_TAG_WIDTH-1] SHALL mean 1=write, 0=read.
REQ-003 Parameter MEM_WORDS, default 4096, SHALL set the backing store depth in BUS_DATA_WIDTH words (power of 2).
REQ-004 Parameter RD_LATENCY, default 4, SHALL set the cycles from read-address acceptance to the first response beat (legal range 1..15).
REQ-005 Ports: clk in 1 clock; reset in 1 async active-high; bus_reqcyc in 1 request valid; bus_req in BUS_DATA_WIDTH address or write data; bus_reqtag in BUS_TAG_WIDTH request tag; bus_reqack out 1 request accepted; bus_respcyc out 1 response beat valid; bus_resp out BUS_DATA_WIDTH read data; bus_resptag out BUS_TAG_WIDTH echoed tag; bus_respack in 1 beat consumed.
REQ-006 One clock domain (clk); reset SHALL be asynchronous and active-high.

Function
REQ-007 Transaction = 8-beat burst on a 64-byte-aligned line; address bits [5:0] of bus_req SHALL be ignored.
REQ-008 Word index = (bus_req[63:6] * 8 + beat) mod MEM_WORDS; out-of-range addresses SHALL wrap silently.
REQ-009 FSM states: IDLE, RD_WAIT, RD_BURST, WR_DATA.
REQ-010 IDLE: on bus_reqcyc=1, SHALL assert bus_reqack for exactly one cycle, latch address and tag, and go to RD_WAIT (tag MSB 0) or WR_DATA (tag MSB 1).
REQ-011 RD_WAIT: a down-counter SHALL count RD_LATENCY cycles, then go to RD_BURST.
REQ-012 RD_BURST: bus_respcyc=1, bus_resp=word[beat], bus_resptag=latched tag; beat SHALL advance only in a cycle with bus_respcyc=1 and bus_respack=1; bus_resp SHALL stay stable while bus_respack=0.
REQ-013 After beat 7 is acked, SHALL return to IDLE; bus_respcyc SHALL deassert in the next cycle.
REQ-014 WR_DATA: each cycle with bus_reqcyc=1 SHALL write bus_req to word[beat], pulse bus_reqack for that cycle and advance beat; after beat 7, SHALL return to IDLE.
REQ-015 Writes SHALL NOT produce response beats; bus_respcyc SHALL stay 0 during WR_DATA.
REQ-016 bus_reqcyc in RD_WAIT/RD_BURST SHALL be ignored (no ack) until IDLE; one outstanding transaction maximum.
REQ-017 Back-to-back: the cycle after returning to IDLE, a pending bus_reqcyc SHALL be accepted (no dead cycle beyond the IDLE cycle).
REQ-018 Read-after-write to the same line SHALL return the newly written data.
REQ-019 The beat counter SHALL be 3 bits and wrap 7->0 at burst end.

Reset
REQ-020 Reset SHALL force IDLE, beat=0, latency counter=0, and bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0 immediately (asynchronously).
REQ-021 Reset mid-burst SHALL abort the transaction with no further beats; memory contents SHALL NOT be cleared; partially written lines retain the beats written.

Structure
REQ-022 Package bus_pkg SHALL hold BUS_DATA_WIDTH, BUS_TAG_WIDTH, BURST_LEN=8, the tag write-bit position and the FSM state enum.
REQ-023 Storage SHALL be a sub-module bus_mem_array (single-port, synchronous write, combinational or registered read with the latency absorbed in RD_WAIT).
REQ-024 An optional simulation-only preload (initial $readmemh) SHALL be permitted in bus_mem_array.

Verification
REQ-025 Write burst addr 0x1000, tag 0x1005, data 0x11..0x88 then read addr 0x1000, tag 0x0005 -> 8 beats 0x11..0x88 in order, bus_resptag=0x0005, first beat RD_LATENCY+1 cycles after ack.
REQ-026 Read addr 0x1038 (unaligned) -> same data as addr 0x1000.
REQ-027 Read with bus_respack held 0 for 3 cycles at beat 2 -> bus_resp holds beat 2 value, no beat skipped, 8 beats total.
REQ-028 Assert bus_reqcyc during RD_BURST -> no bus_reqack until the burst completes; then accepted next IDLE cycle.
REQ-029 Assert reset at read beat 4 -> bus_respcyc=0 same cycle, FSM IDLE; subsequent read of the line returns the original data.
REQ-030 Read addr MEM_WORDS*8 + 0x1000 -> data of addr 0x1000 (wrap).

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants and FSM state type for the burst memory responder.
// Module parameters default to these values; the enum is shared by the top and the bench.
package bus_pkg;

    localparam int BUS_DATA_WIDTH   = 64;
    localparam int BUS_TAG_WIDTH    = 13;
    localparam int BURST_LEN        = 8;
    localparam int TAG_WR_BIT       = BUS_TAG_WIDTH - 1;
    localparam int LINE_OFFSET_BITS = 6;
    localparam int LAT_CNT_WIDTH    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_DATA  = 2'd3
    } bus_state_t;

endpackage

// File: rtl/bus_mem_array.sv
// Single-port backing store: synchronous write, registered read-first output.
// Contents are never reset, so an aborted transaction leaves memory as it was.
module bus_mem_array #(
    parameter int DATA_WIDTH = bus_pkg::BUS_DATA_WIDTH,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/bus_mem_responder.sv
// Tagged 8-beat burst memory responder: one outstanding read or write line at a time.
// The memory read register is filled during RD_WAIT, so beat 0 is ready on entry to RD_BURST.
module bus_mem_responder #(
    parameter int BUS_DATA_WIDTH = bus_pkg::BUS_DATA_WIDTH,
    parameter int BUS_TAG_WIDTH  = bus_pkg::BUS_TAG_WIDTH,
    parameter int MEM_WORDS      = 4096,
    parameter int RD_LATENCY     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    import bus_pkg::*;

    localparam int AW     = $clog2(MEM_WORDS);
    localparam int BW     = $clog2(BURST_LEN);
    localparam int LW     = BUS_DATA_WIDTH - LINE_OFFSET_BITS;
    localparam int WR_BIT = BUS_TAG_WIDTH - 1;

    localparam logic [LAT_CNT_WIDTH-1:0] LAT_LOAD  = LAT_CNT_WIDTH'(RD_LATENCY - 1);
    localparam logic [BW-1:0]            LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0]            BEAT_ONE  = BW'(1);

    bus_state_t               state_reg, state_next;
    logic [BW-1:0]            beat_reg, beat_next;
    logic [LAT_CNT_WIDTH-1:0] lat_reg, lat_next;
    logic [LW-1:0]            line_reg, line_next;
    logic [BUS_TAG_WIDTH-1:0] tag_reg, tag_next;

    logic                      req_ack;
    logic                      mem_we;
    logic [BW-1:0]             addr_beat;
    logic [AW-1:0]             mem_addr;
    logic [BUS_DATA_WIDTH-1:0] mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            lat_reg   <= '0;
            line_reg  <= '0;
            tag_reg   <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            lat_reg   <= lat_next;
            line_reg  <= line_next;
            tag_reg   <= tag_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        lat_next   = lat_reg;
        line_next  = line_reg;
        tag_next   = tag_reg;
        req_ack    = 1'b0;
        mem_we     = 1'b0;
        addr_beat  = beat_reg;

        case (state_reg)
            IDLE: begin
                if (bus_reqcyc) begin
                    req_ack   = 1'b1;
                    line_next = bus_req[BUS_DATA_WIDTH-1:LINE_OFFSET_BITS];
                    tag_next  = bus_reqtag;
                    beat_next = '0;
                    lat_next  = LAT_LOAD;
                    state_next = bus_reqtag[WR_BIT] ? WR_DATA : RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (lat_reg == '0) begin
                    state_next = RD_BURST;
                end else begin
                    lat_next = lat_reg - LAT_CNT_WIDTH'(1);
                end
            end

            RD_BURST: begin
                // Look one word ahead on an acked beat so the registered read lands in time.
                if (bus_respack) begin
                    beat_next = beat_reg + BEAT_ONE;
                    addr_beat = beat_reg + BEAT_ONE;
                    if (beat_reg == LAST_BEAT) begin
                        state_next = IDLE;
                    end
                end
            end

            WR_DATA: begin
                if (bus_reqcyc) begin
                    req_ack   = 1'b1;
                    mem_we    = 1'b1;
                    beat_next = beat_reg + BEAT_ONE;
                    if (beat_reg == LAST_BEAT) begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Line number times 8 plus beat, truncated to the array depth: addresses wrap silently.
        mem_addr = AW'({line_reg, addr_beat});
    end

    bus_mem_array #(
        .DATA_WIDTH (BUS_DATA_WIDTH),
        .DEPTH      (MEM_WORDS),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (bus_req),
        .rdata (mem_rdata)
    );

    // Gate with reset so a request held during reset is never acknowledged.
    assign bus_reqack  = req_ack & ~reset;
    assign bus_respcyc = (state_reg == RD_BURST);
    assign bus_resp    = bus_respcyc ? mem_rdata : '0;
    assign bus_resptag = tag_reg;

endmodule
